// File: rtl/pilot_avg_bank_pkg.sv
// Shared channel-estimation definitions: pilot averager state encoding and
// default sizing used by the pilot averaging bank and its helpers.
package pilot_avg_bank_pkg;

    localparam int DEF_W_PILOT   = 16;
    localparam int DEF_N_SLOT    = 4;
    localparam int DEF_LOG2_NMAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pilot_avg_bank_round_sat.sv
// avg_round_sat: divides an accumulator by 2^n with round-half-up and
// saturates the quotient to a signed W_OUT-bit result. Purely combinational.
module avg_round_sat #(
    parameter int W_ACC = 19,
    parameter int W_OUT = 16,
    parameter int W_N   = 2
) (
    input  logic signed [W_ACC-1:0] acc,
    input  logic        [W_N-1:0]   n,
    output logic signed [W_OUT-1:0] avg
);

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    localparam logic signed [W_ACC:0] MAX_V = {{(W_ACC-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_ACC:0] MIN_V = {{(W_ACC-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}};

    logic signed [W_ACC:0] rnd;
    logic signed [W_ACC:0] sum;
    logic signed [W_ACC:0] shifted;

    // Add half an LSB of the quotient, arithmetic-shift, then clamp.
    always_comb begin
        // NOTE: every variable gets a default at the top so no path leaves it
        // unassigned; a missing default here would infer a latch.
        rnd = '0;
        if (n != '0) begin
            rnd = (W_ACC+1)'(1) << (n - W_N'(1));
        end
        sum     = {acc[W_ACC-1], acc} + rnd;
        shifted = sum >>> n;
        if (shifted > MAX_V) begin
            avg = MAX_V[W_OUT-1:0];
        end else if (shifted < MIN_V) begin
            avg = MIN_V[W_OUT-1:0];
        end else begin
            avg = shifted[W_OUT-1:0];
        end
    end

endmodule

// File: rtl/pilot_avg_bank.sv
// Pilot averaging bank: accumulates 2^n complex pilot samples in each of
// N_SLOT slots, then presents the rounded, saturated averages for readout.
module pilot_avg_bank
    import pilot_avg_bank_pkg::*;
#(
    parameter int W_PILOT   = DEF_W_PILOT,
    parameter int N_SLOT    = DEF_N_SLOT,
    parameter int LOG2_NMAX = DEF_LOG2_NMAX
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(LOG2_NMAX+1)-1:0]    cfg_log2_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [$clog2(N_SLOT)-1:0]         in_addr,
    input  logic signed [W_PILOT-1:0]         in_re,
    input  logic signed [W_PILOT-1:0]         in_im,
    input  logic [$clog2(N_SLOT)-1:0]         rd_addr,
    output logic signed [W_PILOT-1:0]         rd_re,
    output logic signed [W_PILOT-1:0]         rd_im,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int NW  = $clog2(LOG2_NMAX+1);
    localparam int AW  = $clog2(N_SLOT);
    localparam int ACW = W_PILOT + LOG2_NMAX;
    localparam int CW  = LOG2_NMAX + 1;
    localparam logic [AW:0]   N_SLOT_V = (AW+1)'(N_SLOT);
    localparam logic [NW-1:0] NMAX_V   = NW'(LOG2_NMAX);

    typedef struct packed {
        logic [ACW-1:0] acc_re;
        logic [ACW-1:0] acc_im;
        logic [CW-1:0]  cnt;
    } slot_t;

    state_t         state;
    logic [NW-1:0]  n_q;
    slot_t          slots [N_SLOT];
    logic [CW-1:0]  target;
    logic           xfer;
    logic           addr_ok;
    logic           xfer_good;
    logic           xfer_bad;
    logic           last_fill;
    logic [ACW-1:0] ext_re;
    logic [ACW-1:0] ext_im;
    logic [ACW-1:0] sel_re;
    logic [ACW-1:0] sel_im;
    logic signed [W_PILOT-1:0] avg_re;
    logic signed [W_PILOT-1:0] avg_im;

    // busy is a registered copy of "state is ACCUM", so it doubles as ready.
    assign in_ready = busy;
    assign target   = CW'(1) << n_q;
    assign ext_re   = {{LOG2_NMAX{in_re[W_PILOT-1]}}, in_re};
    assign ext_im   = {{LOG2_NMAX{in_im[W_PILOT-1]}}, in_im};

    // Classify the current beat and detect the one that fills the last slot.
    always_comb begin
        xfer      = in_valid && in_ready && !start;
        addr_ok   = ({1'b0, in_addr} < N_SLOT_V);
        xfer_good = 1'b0;
        if (xfer && addr_ok) begin
            xfer_good = (slots[in_addr].cnt < target);
        end
        xfer_bad  = xfer && !xfer_good;
        last_fill = xfer_good;
        for (int k = 0; k < N_SLOT; k++) begin
            if (AW'(k) == in_addr) begin
                if (slots[k].cnt + CW'(1) != target) last_fill = 1'b0;
            end else if (slots[k].cnt != target) begin
                last_fill = 1'b0;
            end
        end
    end

    // Select the slot addressed for readout; unmapped addresses read as zero.
    always_comb begin
        sel_re = '0;
        sel_im = '0;
        if ({1'b0, rd_addr} < N_SLOT_V) begin
            sel_re = slots[rd_addr].acc_re;
            sel_im = slots[rd_addr].acc_im;
        end
    end

    avg_round_sat #(.W_ACC(ACW), .W_OUT(W_PILOT), .W_N(NW)) u_avg_re (
        .acc (sel_re),
        .n   (n_q),
        .avg (avg_re)
    );

    avg_round_sat #(.W_ACC(ACW), .W_OUT(W_PILOT), .W_N(NW)) u_avg_im (
        .acc (sel_im),
        .n   (n_q),
        .avg (avg_im)
    );

    // Control FSM with registered status flags; start overrides everything.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state <= ST_IDLE;
            n_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (start) begin
                state <= ST_ACCUM;
                n_q   <= (cfg_log2_n > NMAX_V) ? NMAX_V : cfg_log2_n;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else if (state == ST_ACCUM) begin
                err <= xfer_bad;
                if (last_fill) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    // Per-slot accumulators and sample counters.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this array is deliberately reset; a fresh run must never see
        // partial sums left behind by an abandoned one.
        if (!rst) begin
            for (int k = 0; k < N_SLOT; k++) slots[k] <= '0;
        end else if (start) begin
            for (int k = 0; k < N_SLOT; k++) slots[k] <= '0;
        end else if (xfer_good) begin
            slots[in_addr].acc_re <= slots[in_addr].acc_re + ext_re;
            slots[in_addr].acc_im <= slots[in_addr].acc_im + ext_im;
            slots[in_addr].cnt    <= slots[in_addr].cnt + CW'(1);
        end
    end

    // Registered readout; forced to zero outside DONE and on start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_re <= '0;
            rd_im <= '0;
        end else if (state == ST_DONE && !start) begin
            rd_re <= avg_re;
            rd_im <= avg_im;
        end else begin
            rd_re <= '0;
            rd_im <= '0;
        end
    end

endmodule

// File: tb/tb_pilot_avg_bank.sv
// Self-checking bench for pilot_avg_bank: expected averages are queued as
// each run is driven and popped as the slots are read back.
module tb_pilot_avg_bank;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        cfg_log2_n = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_addr = '0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic [1:0]        rd_addr = '0;
    logic signed [15:0] rd_re;
    logic signed [15:0] rd_im;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int re;
        int im;
    } exp_t;

    exp_t sb[$];

    pilot_avg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_log2_n (cfg_log2_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_re      (in_re),
        .in_im      (in_im),
        .rd_addr    (rd_addr),
        .rd_re      (rd_re),
        .rd_im      (rd_im),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference average: floor((sum + half) / 2^n), clamped to 16-bit signed.
    function automatic int ref_avg(input longint sum, input int n);
        longint d, t, q;
        d = longint'(1) << n;
        t = sum + ((n > 0) ? d / 2 : 0);
        q = t / d;
        if ((t % d != 0) && (t < 0)) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic push(input int re, input int im);
        exp_t e;
        e.re = re;
        e.im = im;
        sb.push_back(e);
    endtask

    task automatic send(input int a, input int re, input int im);
        in_addr  = 2'(a);
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        cfg_log2_n = 2'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic read_slot(input int a, input string tag);
        exp_t e;
        rd_addr = 2'(a);
        @(negedge clk);
        if (sb.size() == 0) begin
            check($sformatf("%s_s%0d_sb_empty", tag, a), 1, 0);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s_s%0d_re", tag, a), rd_re, e.re);
            check($sformatf("%s_s%0d_im", tag, a), rd_im, e.im);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r1[8], i1[8], r3[8], i3[8];
        longint sr1, si1, sr3, si3;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", in_ready, 0);
        check("rst_rd_re", rd_re, 0);
        check("rst_rd_im", rd_im, 0);
        rst = 1'b1;
        @(negedge clk);

        // n=0, one beat per slot
        do_start(0);
        check("t1_busy", busy, 1);
        check("t1_ready", in_ready, 1);
        check("t1_done_low", done, 0);
        push(100, 5); push(-7, -1); push(0, -32768); push(32767, 1);
        send(0, 100, 5);
        send(1, -7, -1);
        send(2, 0, -32768);
        check("t1_done_early", done, 0);
        send(3, 32767, 1);
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        check("t1_ready_off", in_ready, 0);
        for (int a = 0; a < 4; a++) read_slot(a, "t1");

        // n=1 rounding, plus an overfill beat that must be dropped
        do_start(1);
        check("t2_rd_cleared", rd_re, 0);
        push(4, 0); push(-3, 1); push(8, -5); push(1, 0);
        send(0, 3, 10);
        send(0, 4, -10);
        check("t2_err_fill", err, 0);
        send(0, 1000, 1000);
        check("t2_err_pulse", err, 1);
        @(negedge clk);
        check("t2_err_clear", err, 0);
        send(1, -3, 1);
        send(1, -4, 1);
        send(2, 7, -5);
        send(2, 8, -6);
        send(3, 0, -1);
        check("t2_done_early", done, 0);
        send(3, 1, 0);
        check("t2_done", done, 1);
        for (int a = 0; a < 4; a++) read_slot(a, "t2");

        // n=3 full-scale extremes and random slots
        sr1 = 0; si1 = 0; sr3 = 0; si3 = 0;
        for (int j = 0; j < 8; j++) begin
            r1[j] = int'($urandom_range(0, 65535)) - 32768;
            i1[j] = int'($urandom_range(0, 65535)) - 32768;
            r3[j] = int'($urandom_range(0, 65535)) - 32768;
            i3[j] = int'($urandom_range(0, 65535)) - 32768;
            sr1 += r1[j]; si1 += i1[j]; sr3 += r3[j]; si3 += i3[j];
        end
        do_start(3);
        push(-32768, 32767);
        push(ref_avg(sr1, 3), ref_avg(si1, 3));
        push(32767, -32768);
        push(ref_avg(sr3, 3), ref_avg(si3, 3));
        for (int j = 0; j < 8; j++) begin
            send(0, -32768, 32767);
            send(1, r1[j], i1[j]);
            send(2, 32767, -32768);
            send(3, r3[j], i3[j]);
            if (j == 6) check("t3_done_early", done, 0);
        end
        check("t3_done", done, 1);
        for (int a = 0; a < 4; a++) read_slot(a, "t3");

        // start coinciding with a beat mid-run
        do_start(1);
        send(0, 5, 5);
        send(2, 7, 7);
        start      = 1'b1;
        cfg_log2_n = 2'd1;
        in_addr    = 2'd1;
        in_re      = 16'sd99;
        in_im      = 16'sd99;
        in_valid   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("t4_err", err, 0);
        check("t4_busy", busy, 1);
        check("t4_ready", in_ready, 1);
        check("t4_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            push(10 * k + 21, -(10 * k + 20));
            send(k, 10 * k + 20, -(10 * k + 20));
            send(k, 10 * k + 21, -(10 * k + 21));
            check($sformatf("t4_err_s%0d", k), err, 0);
        end
        check("t4_done_end", done, 1);
        for (int a = 0; a < 4; a++) read_slot(a, "t4");

        // reset in the middle of an accumulation
        do_start(0);
        send(0, 1234, -1234);
        send(1, 11, 11);
        #2 rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_ready", in_ready, 0);
        check("t5_done", done, 0);
        check("t5_err", err, 0);
        check("t5_rd_re", rd_re, 0);
        check("t5_rd_im", rd_im, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        send(0, 50, 50);
        check("t5_idle_err", err, 0);
        rd_addr = 2'd0;
        @(negedge clk);
        check("t5_idle_rd", rd_re, 0);
        do_start(0);
        push(-1, 2); push(2, -3); push(3, 4); push(-32768, 32767);
        send(0, -1, 2);
        send(1, 2, -3);
        send(2, 3, 4);
        check("t5_accum_rd", rd_re, 0);
        send(3, -32768, 32767);
        check("t5_done_end", done, 1);
        for (int a = 0; a < 4; a++) read_slot(a, "t5");

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pilot_avg_bank.md
PILOT_AVG_BANK -- requirements
Module: pilot_avg_bank

Interface
REQ-001 SHALL have parameter W_PILOT, default 16, meaning signed width of each real/imag pilot input and averaged output.
REQ-002 SHALL have parameter N_SLOT, default 4, meaning number of pilot subcarrier slots averaged independently.
REQ-003 SHALL have parameter LOG2_NMAX, default 3, meaning maximum averaging depth exponent (up to 8 samples per slot).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that clears all slots, latches cfg_log2_n and begins a new accumulation.
REQ-007 SHALL have port cfg_log2_n, input, $clog2(LOG2_NMAX+1), samples per slot = 2^cfg_log2_n; sampled only on start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_addr (input, $clog2(N_SLOT)), in_re and in_im (input, W_PILOT, signed): sample stream.
REQ-009 SHALL have ports rd_addr (input, $clog2(N_SLOT)), rd_re and rd_im (output, W_PILOT, signed): averaged-result readout.
REQ-010 SHALL have outputs busy (1), done (1) and err (1): status flags.

Function
REQ-011 SHALL implement states IDLE, ACCUM and DONE.
REQ-012 SHALL move from any state to ACCUM on start, clearing every accumulator and per-slot counter in that cycle.
REQ-013 SHALL drive in_ready=1 only in ACCUM; a beat transfers when in_valid and in_ready are both high.
REQ-014 SHALL, on transfer to slot k whose count is below 2^n, add in_re/in_im sign-extended into acc_re[k]/acc_im[k] (width W_PILOT+LOG2_NMAX, no overflow possible) and increment count[k].
REQ-015 SHALL, on transfer to a slot already holding 2^n samples, or with in_addr >= N_SLOT, drop the sample and pulse err high for one cycle.
REQ-016 SHALL move ACCUM->DONE in the cycle after the transfer that completes the last unfilled slot; done SHALL be a level, high only in DONE.
REQ-017 SHALL give start priority over a same-cycle transfer: the beat is discarded and no err is raised.
REQ-018 SHALL compute each average as (acc + 2^(n-1)) >>> n (round half up; no rounding term when n=0), saturated to the signed W_PILOT range.
REQ-019 SHALL register rd_re/rd_im with one-cycle latency from rd_addr; in states other than DONE they SHALL read 0.
REQ-020 SHALL drive busy=1 exactly in ACCUM.

Reset
REQ-021 SHALL, on rst low, asynchronously enter IDLE and clear all accumulators, counters, latched n, rd_re, rd_im, err, done and busy to 0.
REQ-022 SHALL abandon any in-progress accumulation on reset; results are lost and the next start is required.

Structure
REQ-023 SHALL take state encoding (IDLE/ACCUM/DONE) and default parameter values from the shared channel-estimation package.
REQ-024 SHALL instantiate sub-module avg_round_sat twice (real, imag); it performs REQ-018 rounding and saturation combinationally.
REQ-025 SHALL keep the per-slot accumulators and counters in a single register array indexed by slot.

Verification
REQ-026 Reset then n=0, one beat per slot: re = 100, -7, 0, 32767 -> done one cycle after last beat; rd_re = 100, -7, 0, 32767.
REQ-027 n=1, slot 0 samples re 3 and 4 -> rd_re = 4 (3.5 rounded up); slot 1 samples -3 and -4 -> -3.
REQ-028 n=3, eight beats re=32767 to slot 2 -> rd_re = 32767; eight beats -32768 -> -32768 (no wrap).
REQ-029 n=1, third beat to a filled slot -> err pulses one cycle, sample dropped, accumulator unchanged.
REQ-030 start asserted together with in_valid mid-ACCUM -> all slots cleared, beat dropped, err stays 0, busy stays 1.
REQ-031 rst low mid-ACCUM -> IDLE, busy=0, in_ready=0, rd_re/rd_im=0 until next start and completion.
